// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store access controller.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Byte lanes touched by an access of this width, before shifting by the address offset
   function automatic logic [3:0] size_mask(input logic [2:0] func3);
      case (func3)
         F3_B, F3_BU: size_mask = 4'b0001;
         F3_H, F3_HU: size_mask = 4'b0011;
         F3_W:        size_mask = 4'b1111;
         default:     size_mask = 4'b0000;
      endcase
   endfunction

   // Stores only come in signed widths; loads also have the unsigned byte/half forms
   function automatic logic func3_legal(input logic store, input logic [2:0] func3);
      if (store) begin
         func3_legal = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W);
      end else begin
         func3_legal = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W) ||
                       (func3 == F3_BU) || (func3 == F3_HU);
      end
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: beat masks, shifted store data, and load beat merge/extend.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]  func3,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic        wr_beat,
   input  logic        rd_beat,
   input  logic [31:0] rdata,
   input  logic [31:0] merged,
   output logic        split,
   output logic [3:0]  beat_mask,
   output logic [31:0] beat_wdata,
   output logic [31:0] merge_next,
   output logic [31:0] load_data
);

   logic [7:0] m8;
   logic [5:0] lo_shift;
   logic [5:0] hi_shift;

   // Eight-lane mask spans two words; the upper nibble belongs to the second beat
   assign m8       = {4'b0000, size_mask(func3)} << off;
   assign lo_shift = {1'b0, off, 3'b000};
   assign hi_shift = 6'd32 - lo_shift;
   assign split    = |m8[7:4];

   // Lanes and data for the beat about to be issued
   always_comb begin
      beat_mask  = m8[3:0];
      beat_wdata = wdata << lo_shift;
      if (wr_beat) begin
         beat_mask  = m8[7:4];
         beat_wdata = wdata >> hi_shift;
      end
   end

   // Fold the returning read word into the right-aligned result
   always_comb begin
      merge_next = rdata >> lo_shift;
      if (rd_beat) begin
         merge_next = merged | (rdata << hi_shift);
      end
   end

   // Width-dependent sign or zero extension of the merged value
   always_comb begin
      case (func3)
         F3_B:    load_data = {{24{merge_next[7]}}, merge_next[7:0]};
         F3_H:    load_data = {{16{merge_next[15]}}, merge_next[15:0]};
         F3_BU:   load_data = {24'h000000, merge_next[7:0]};
         F3_HU:   load_data = {16'h0000, merge_next[15:0]};
         default: load_data = merge_next;
      endcase
   end

endmodule

// File: rtl/lsu_access_ctrl.sv
// Multi-cycle controller sequencing core loads/stores onto a word-wide memory port.
module lsu_access_ctrl
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int ADDR_W  = 32
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_func3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_req,
   input  logic              mem_gnt,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wmask,
   output logic [31:0]       mem_wdata,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t            state;
   logic              beat;
   logic [CNT_W-1:0]  tcnt;
   logic [31:0]       merged;

   logic              lat_store;
   logic [2:0]        lat_func3;
   logic [ADDR_W-1:0] lat_addr;
   logic [31:0]       lat_wdata;
   logic              lat_legal;

   logic              idle;
   logic              req_legal;
   logic [2:0]        src_func3;
   logic [1:0]        src_off;
   logic [31:0]       src_wdata;
   logic              lane_split;
   logic [3:0]        lane_mask;
   logic [31:0]       lane_wdata;
   logic [31:0]       merge_next;
   logic [31:0]       load_data;

   // While idle the lane logic looks at the incoming request so beat 0 can be registered on accept
   assign idle      = (state == IDLE);
   assign req_legal = func3_legal(req_store, req_func3);
   assign src_func3 = idle ? req_func3      : lat_func3;
   assign src_off   = idle ? req_addr[1:0]  : lat_addr[1:0];
   assign src_wdata = idle ? req_wdata      : lat_wdata;

   lsu_lane_align u_lane (
      .func3      (src_func3),
      .off        (src_off),
      .wdata      (src_wdata),
      .wr_beat    (!idle),
      .rd_beat    (beat),
      .rdata      (mem_rdata),
      .merged     (merged),
      .split      (lane_split),
      .beat_mask  (lane_mask),
      .beat_wdata (lane_wdata),
      .merge_next (merge_next),
      .load_data  (load_data)
   );

   // Access FSM with registered handshake, memory and response outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wmask  <= '0;
         mem_wdata  <= '0;
         beat       <= 1'b0;
         tcnt       <= '0;
         merged     <= '0;
         lat_store  <= 1'b0;
         lat_func3  <= '0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_legal  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  state     <= ISSUE;
                  req_ready <= 1'b0;
                  beat      <= 1'b0;
                  tcnt      <= '0;
                  merged    <= '0;
                  lat_store <= req_store;
                  lat_func3 <= req_func3;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  lat_legal <= req_legal;
                  if (req_legal) begin
                     mem_req   <= 1'b1;
                     mem_we    <= req_store;
                     mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                     mem_wmask <= lane_mask;
                     mem_wdata <= req_store ? lane_wdata : 32'h0;
                  end
               end
            end
            ISSUE: begin
               if (!lat_legal) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end else if (mem_gnt) begin
                  state   <= WAIT;
                  mem_req <= 1'b0;
                  tcnt    <= '0;
               end else if (tcnt == CNT_LAST) begin
                  state      <= RESP;
                  mem_req    <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end else begin
                  tcnt <= tcnt + CNT_W'(1);
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  merged <= merge_next;
                  if (lane_split && !beat) begin
                     state     <= ISSUE;
                     beat      <= 1'b1;
                     tcnt      <= '0;
                     mem_req   <= 1'b1;
                     mem_addr  <= {lat_addr[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
                     mem_wmask <= lane_mask;
                     mem_wdata <= lat_store ? lane_wdata : 32'h0;
                  end else begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b0;
                     resp_rdata <= lat_store ? 32'h0 : load_data;
                  end
               end else if (tcnt == CNT_LAST) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end else begin
                  tcnt <= tcnt + CNT_W'(1);
               end
            end
            RESP: begin
               state      <= IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
